// File: rtl/fake_lut_pipe_array.sv
// Programmable per-lane truth-table lookup behind a stallable valid/ready pipeline,
// with saturating per-lane counters of asserted results seen at the output handshake.

module fake_lut_lane_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority over a coincident increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

module fake_lut_pipe_array #(
    parameter int                CHANNELS    = 4,
    parameter int                IN_W        = 7,
    parameter int                STAGES      = 2,
    parameter logic [2**IN_W-1:0] TRUTH_TABLE = '0,
    parameter int                CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*IN_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       out_data,
    input  logic                      clear_counts,
    output logic [CHANNELS*CNT_W-1:0] hit_count
);
    logic [STAGES-1:0]                vld_q, vld_d, adv;
    logic [STAGES-1:0][CHANNELS-1:0]  dat_q, dat_d;
    logic [CHANNELS-1:0]              lut_res;
    logic                             accept, out_hs;

    // Stage k moves iff some stage at or after it is empty, or the output drains;
    // written as a reduction so there is no combinational chain through adv itself.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = out_ready | ~(&vld_q[STAGES-1:k]);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lut
        assign lut_res[c] = TRUTH_TABLE[in_data[c*IN_W +: IN_W]];
    end

    assign in_ready = ~rst & adv[0];
    assign accept   = in_valid & in_ready;

    // Data regs only load on a valid beat so the output holds its last value.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (adv[0]) begin
            vld_d[0] = accept;
            if (accept) dat_d[0] = lut_res;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) dat_d[k] = dat_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = dat_q[STAGES-1];
    assign out_hs    = out_valid & out_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt
        fake_lut_lane_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (out_hs & out_data[c]),
            .clr (clear_counts),
            .cnt (hit_count[c*CNT_W +: CNT_W])
        );
    end
endmodule
